cpu_trace_parser: RTL and testbench
===================================

CPU_TRACE_PARSER -- requirements
Module: cpu_trace_parser

Interface
REQ-001 SHALL have parameter TIME_DIGITS, default 4; the maximum number of decimal digits in the time field.
REQ-002 SHALL have parameter REG_DIGITS, default 4; the maximum number of decimal digits in the register field.
REQ-003 SHALL have parameter HEX_DIGITS, default 8; the exact number of hex digits in the pc, addr and data fields.
REQ-004 SHALL have parameter CNT_W, default 16; the width of the line counters.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-007 SHALL have port char, input, 8 bits: the ASCII character sampled every clock.
REQ-008 SHALL have port format_type, output, 2 bits: 00 none, 01 register-write line, 10 memory-write line.
REQ-009 SHALL have port time_val, output, 16 bits: the binary value of the time field.
REQ-010 SHALL have port pc_val, output, 4*HEX_DIGITS bits: the pc field.
REQ-011 SHALL have port dest_val, output, 4*HEX_DIGITS bits: the register number (binary, zero-extended) or the memory address.
REQ-012 SHALL have port data_val, output, 4*HEX_DIGITS bits: the data field.
REQ-013 SHALL have ports ok_count and err_count, output, CNT_W bits each: the accepted-line and rejected-line counts.

Function
REQ-014 SHALL accept the grammar: ^ D{1..TIME_DIGITS} @ H{HEX_DIGITS} : SP* ( $ D{1..REG_DIGITS} | * H{HEX_DIGITS} ) SP* <= SP* H{HEX_DIGITS} #.
REQ-015 SHALL treat D as '0'-'9' and H as '0'-'9' or 'a'-'f'.
REQ-016 SHALL implement these FSM states: IDLE, TIME, PC, SEP, REG, ADDR, SP1, LT, SP2, DATA, DONE.
REQ-017 SHALL move to TIME from any state on '^', clearing the digit counters and the shadow field registers; '^' always restarts a line.
REQ-018 SHALL treat any other character that violates the grammar as aborting the line and returning to IDLE.
REQ-019 SHALL treat a digit beyond the TIME_DIGITS, REG_DIGITS or HEX_DIGITS count as a violation.
REQ-020 SHALL treat a terminator arriving before a fixed-length hex field is complete as a violation.
REQ-021 SHALL accumulate shadow fields per character: decimal fields as acc*10+d, truncated to 16 bits; hex fields as {acc,nibble}.
REQ-022 SHALL, on '#' in DATA with exactly HEX_DIGITS digits, copy the shadow fields to time_val, pc_val, dest_val and data_val at the same edge that sets format_type.
REQ-023 SHALL hold format_type non-zero for exactly one cycle (the cycle after '#' is sampled) and then return it to 00.
REQ-024 SHALL hold the field outputs until the next accepted line.
REQ-025 SHALL increment ok_count on each accepted line.
REQ-026 SHALL increment err_count once per line that reached TIME and then aborted, whether by violation or by restart with '^'.
REQ-027 SHALL saturate both counters at all-ones with no wrap-around.
REQ-028 SHALL, in DONE, treat '^' as starting a new line without an error count, and any other character as returning to IDLE without an error count.
REQ-029 SHALL NOT count characters received in IDLE as errors.

Reset
REQ-030 SHALL, while reset=0, force state to IDLE and format_type, all field outputs, both counters and all internal counters to 0, asynchronously.
REQ-031 SHALL discard any line in progress when reset is asserted, without counting it.
REQ-032 SHALL sample the first character at the first rising edge after reset is released.

Configuration
REQ-033 SHALL, when macro CPU_TRACE_UPPER_HEX_EN is defined, also accept 'A'-'F' as H, with nibble values 10-15.
REQ-034 SHALL, when CPU_TRACE_UPPER_HEX_EN is not defined, treat 'A'-'F' as a violation.
REQ-035 SHALL leave decimal fields unaffected by CPU_TRACE_UPPER_HEX_EN.

Verification
REQ-036 SHALL cover: "^12@00003000: $5 <= 0000000a#" -> format_type=01 for one cycle; time_val=12, pc_val=0x3000, dest_val=5, data_val=0xa, ok_count=1.
REQ-037 SHALL cover: "^9999@0000300c: *00001004<=deadbeef#" -> format_type=10; dest_val=0x1004, data_val=0xdeadbeef.
REQ-038 SHALL cover: "^12345@..." with the default parameters -> no format_type pulse; err_count=1.
REQ-039 SHALL cover: "^1@0000300" then "^2@00003000: $1 <= 00000001#" -> err_count=1, ok_count=1, time_val=2.
REQ-040 SHALL cover: "...<= DEADBEEF#" -> accepted with CPU_TRACE_UPPER_HEX_EN defined, and err_count+1 with no pulse without it.
REQ-041 SHALL cover: reset=0 asserted mid-line, then released, then a valid line -> counters 0 during reset, no error counted, the next line accepted.

Source files
------------

// File: rtl/cpu_trace_parser.sv
// Parses ASCII CPU trace lines, one character per clock, into register-write / memory-write records.
// Define CPU_TRACE_UPPER_HEX_EN to also accept 'A'-'F' as hex digits.
module cpu_trace_parser #(
  parameter int TIME_DIGITS = 4,
  parameter int REG_DIGITS  = 4,
  parameter int HEX_DIGITS  = 8,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              char,
  output logic [1:0]              format_type,
  output logic [15:0]             time_val,
  output logic [4*HEX_DIGITS-1:0] pc_val,
  output logic [4*HEX_DIGITS-1:0] dest_val,
  output logic [4*HEX_DIGITS-1:0] data_val,
  output logic [CNT_W-1:0]        ok_count,
  output logic [CNT_W-1:0]        err_count
);
  localparam int DW = 4*HEX_DIGITS;

  localparam logic [7:0] C_CARET = 8'h5e, C_AT = 8'h40, C_COLON = 8'h3a, C_DOLLAR = 8'h24;
  localparam logic [7:0] C_STAR = 8'h2a, C_LT = 8'h3c, C_EQ = 8'h3d, C_HASH = 8'h23, C_SP = 8'h20;

  typedef enum logic [3:0] {IDLE, TIME, PC, SEP, REG, ADDR, SP1, LT, SP2, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] time_sh;
  logic [DW-1:0] pc_sh, dest_sh, data_sh;
  logic        mem_sh;

  // {valid, nibble}
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
`ifdef CPU_TRACE_UPPER_HEX_EN
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
`endif
    return 5'd0;
  endfunction

  function automatic logic [15:0] dec_acc(input logic [15:0] acc, input logic [3:0] d);
    return acc * 16'd10 + {12'd0, d};
  endfunction

  logic [4:0] hx;
  logic is_hex, is_dec, is_sp, is_caret;
  logic take_time, take_pc, take_reg, take_addr, take_data, take_any;
  logic active, err_inc, publish;

  assign hx       = hex_dec(char);
  assign is_hex   = hx[4];
  assign is_dec   = (char >= 8'h30) && (char <= 8'h39);
  assign is_sp    = (char == C_SP);
  assign is_caret = (char == C_CARET);

  assign take_time = (state == TIME) && is_dec && (cnt < 8'(TIME_DIGITS));
  assign take_pc   = (state == PC)   && is_hex && (cnt < 8'(HEX_DIGITS));
  assign take_reg  = (state == REG)  && is_dec && (cnt < 8'(REG_DIGITS));
  assign take_addr = (state == ADDR) && is_hex && (cnt < 8'(HEX_DIGITS));
  assign take_data = ((state == SP2) && is_hex) ||
                     ((state == DATA) && is_hex && (cnt < 8'(HEX_DIGITS)));
  assign take_any  = take_time | take_pc | take_reg | take_addr | take_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Anything not explicitly allowed falls through to IDLE (line abort).
  always_comb begin
    state_nxt = IDLE;
    if (is_caret) begin
      state_nxt = TIME;
    end else begin
      case (state)
        TIME: if (take_time) state_nxt = TIME;
              else if (char == C_AT && cnt != 8'd0) state_nxt = PC;
        PC:   if (take_pc) state_nxt = PC;
              else if (char == C_COLON && cnt == 8'(HEX_DIGITS)) state_nxt = SEP;
        SEP:  if (is_sp) state_nxt = SEP;
              else if (char == C_DOLLAR) state_nxt = REG;
              else if (char == C_STAR) state_nxt = ADDR;
        REG:  if (take_reg) state_nxt = REG;
              else if (cnt != 8'd0 && is_sp) state_nxt = SP1;
              else if (cnt != 8'd0 && char == C_LT) state_nxt = LT;
        ADDR: if (take_addr) state_nxt = ADDR;
              else if (cnt == 8'(HEX_DIGITS) && is_sp) state_nxt = SP1;
              else if (cnt == 8'(HEX_DIGITS) && char == C_LT) state_nxt = LT;
        SP1:  if (is_sp) state_nxt = SP1;
              else if (char == C_LT) state_nxt = LT;
        LT:   if (char == C_EQ) state_nxt = SP2;
        SP2:  if (is_sp) state_nxt = SP2;
              else if (is_hex) state_nxt = DATA;
        DATA: if (take_data) state_nxt = DATA;
              else if (char == C_HASH && cnt == 8'(HEX_DIGITS)) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    active  = (state != IDLE) && (state != DONE);
    err_inc = active && (is_caret || state_nxt == IDLE);
    publish = (state == DATA) && (state_nxt == DONE);
    cnt_nxt = cnt;
    if (is_caret)               cnt_nxt = 8'd0;
    else if (take_any)          cnt_nxt = (state == SP2) ? 8'd1 : cnt + 8'd1;
    else if (state_nxt != state) cnt_nxt = 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      time_sh     <= '0;
      pc_sh       <= '0;
      dest_sh     <= '0;
      data_sh     <= '0;
      mem_sh      <= 1'b0;
      format_type <= 2'b00;
      time_val    <= '0;
      pc_val      <= '0;
      dest_val    <= '0;
      data_val    <= '0;
      ok_count    <= '0;
      err_count   <= '0;
    end else begin
      cnt         <= cnt_nxt;
      format_type <= 2'b00;
      if (is_caret) begin
        time_sh <= '0;
        pc_sh   <= '0;
        dest_sh <= '0;
        data_sh <= '0;
        mem_sh  <= 1'b0;
      end else begin
        if (take_time) time_sh <= dec_acc(time_sh, char[3:0]);
        if (take_pc)   pc_sh   <= {pc_sh[DW-5:0], hx[3:0]};
        if (take_reg)  dest_sh <= DW'(dec_acc(dest_sh[15:0], char[3:0]));
        if (take_addr) dest_sh <= {dest_sh[DW-5:0], hx[3:0]};
        if (take_data) data_sh <= {data_sh[DW-5:0], hx[3:0]};
        if (state == SEP && char == C_STAR) mem_sh <= 1'b1;
      end
      if (publish) begin
        format_type <= mem_sh ? 2'b10 : 2'b01;
        time_val    <= time_sh;
        pc_val      <= pc_sh;
        dest_val    <= dest_sh;
        data_val    <= data_sh;
        if (ok_count != '1) ok_count <= ok_count + 1'b1;
      end
      if (err_inc && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_trace_parser.sv
// Random and directed trace lines against a whole-line grammar model of the parser.
module tb_cpu_trace_parser;
  localparam int TD = 4, RD = 4, HD = 8, CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    char = 8'h20;
  logic [1:0]    format_type;
  logic [15:0]   time_val;
  logic [31:0]   pc_val, dest_val, data_val;
  logic [CW-1:0] ok_count, err_count;

  cpu_trace_parser #(.TIME_DIGITS(TD), .REG_DIGITS(RD), .HEX_DIGITS(HD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .char(char), .format_type(format_type),
    .time_val(time_val), .pc_val(pc_val), .dest_val(dest_val), .data_val(data_val),
    .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  bit          m_active;
  string       m_line;
  int          m_ok, m_err;
  logic [1:0]  m_ft;
  logic [15:0] m_time;
  logic [31:0] m_pc, m_dest, m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_d(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  function automatic bit is_h(input logic [7:0] c);
`ifdef CPU_TRACE_UPPER_HEX_EN
    if (c >= "A" && c <= "F") return 1'b1;
`endif
    return is_d(c) || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [31:0] nib(input logic [7:0] c);
    if (is_d(c)) return 32'(c - "0");
    if (c >= "a" && c <= "f") return 32'(c - "a") + 32'd10;
    return 32'(c - "A") + 32'd10;
  endfunction

  // kind: 0 decimal, 1 hex, 2 space
  function automatic int run(input string s, input int p, input int kind);
    int n = 0;
    while (p + n < s.len()) begin
      logic [7:0] c;
      c = s.getc(p + n);
      if (kind == 0 && !is_d(c)) break;
      if (kind == 1 && !is_h(c)) break;
      if (kind == 2 && c != " ") break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] numval(input string s, input int p, input int n, input int base);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v * 32'(base) + nib(s.getc(p + i));
    return v;
  endfunction

  // -1: no valid line starts this way, 0: valid so far, 1: complete line
  function automatic int parse(input string s, output logic [15:0] t, output logic [31:0] pc,
                               output logic [31:0] dst, output logic [31:0] dat, output logic [1:0] ft);
    int p = 1;
    int n;
    int L = s.len();
    t = 0; pc = 0; dst = 0; dat = 0; ft = 0;
    n = run(s, p, 0); if (n > TD) return -1;
    t = 16'(numval(s, p, n, 10)); p += n; if (p == L) return 0;
    if (n == 0 || s.getc(p) != "@") return -1;
    p++; if (p == L) return 0;
    n = run(s, p, 1); if (n > HD) return -1;
    pc = numval(s, p, n, 16); p += n; if (p == L) return 0;
    if (n != HD || s.getc(p) != ":") return -1;
    p++;
    p += run(s, p, 2); if (p == L) return 0;
    if (s.getc(p) == "$") begin
      p++; n = run(s, p, 0); if (n > RD) return -1;
      dst = 32'(16'(numval(s, p, n, 10))); p += n; if (p == L) return 0;
      if (n == 0) return -1;
      ft = 2'b01;
    end else if (s.getc(p) == "*") begin
      p++; n = run(s, p, 1); if (n > HD) return -1;
      dst = numval(s, p, n, 16); p += n; if (p == L) return 0;
      if (n != HD) return -1;
      ft = 2'b10;
    end else return -1;
    p += run(s, p, 2); if (p == L) return 0;
    if (s.getc(p) != "<") return -1;
    p++; if (p == L) return 0;
    if (s.getc(p) != "=") return -1;
    p++;
    p += run(s, p, 2); if (p == L) return 0;
    n = run(s, p, 1); if (n > HD) return -1;
    dat = numval(s, p, n, 16); p += n; if (p == L) return 0;
    if (n != HD || s.getc(p) != "#") return -1;
    return (p + 1 == L) ? 1 : -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_line = ""; m_ok = 0; m_err = 0; m_ft = 0;
    m_time = 0; m_pc = 0; m_dest = 0; m_data = 0;
  endtask

  task automatic model_step(input logic [7:0] c);
    logic [15:0] t;
    logic [31:0] pc, dst, dat;
    logic [1:0]  ft;
    int r;
    m_ft = 2'b00;
    if (c == "^") begin
      if (m_active && m_err < CMAX) m_err++;
      m_active = 1;
      m_line = "^";
    end else if (m_active) begin
      m_line = $sformatf("%s%c", m_line, c);
      r = parse(m_line, t, pc, dst, dat, ft);
      if (r < 0) begin
        if (m_err < CMAX) m_err++;
        m_active = 0;
      end else if (r == 1) begin
        if (m_ok < CMAX) m_ok++;
        m_ft = ft; m_time = t; m_pc = pc; m_dest = dst; m_data = dat;
        m_active = 0;
      end
    end
  endtask

  task automatic apply(input logic [7:0] c);
    char = c;
    @(posedge clk);
    model_step(c);
    @(negedge clk);
    chk("format_type", 32'(format_type), 32'(m_ft));
    chk("ok_count", 32'(ok_count), 32'(m_ok));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("time_val", 32'(time_val), 32'(m_time));
    chk("pc_val", pc_val, m_pc);
    chk("dest_val", dest_val, m_dest);
    chk("data_val", data_val, m_data);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) apply(s.getc(i));
  endtask

  function automatic string rnd_line();
    string hx = "0123456789abcdef";
    string al = "0123456789abcdefABCDEF@:$*<=# ^x";
    string s = "^";
    int k;
    k = $urandom_range(1, TD);
    repeat (k) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
    s = {s, "@"};
    repeat (HD) s = $sformatf("%s%c", s, hx.getc($urandom_range(0, 15)));
    s = {s, ":"};
    repeat ($urandom_range(0, 2)) s = {s, " "};
    if ($urandom_range(0, 1) == 1) begin
      s = {s, "$"};
      k = $urandom_range(1, RD);
      repeat (k) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
    end else begin
      s = {s, "*"};
      repeat (HD) s = $sformatf("%s%c", s, hx.getc($urandom_range(0, 15)));
    end
    repeat ($urandom_range(0, 2)) s = {s, " "};
    s = {s, "<="};
    repeat ($urandom_range(0, 2)) s = {s, " "};
    repeat (HD) s = $sformatf("%s%c", s, hx.getc($urandom_range(0, 15)));
    s = {s, "#"};
    case ($urandom_range(0, 3))
      0: s.putc($urandom_range(1, s.len() - 1), al.getc($urandom_range(0, al.len() - 1)));
      1: s = s.substr(0, $urandom_range(1, s.len() - 1));
      default: ;
    endcase
    return s;
  endfunction

  initial begin
    string junk = "xz #q";
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ok", 32'(ok_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_ft", 32'(format_type), 32'd0);
    chk("rst_data", data_val, 32'd0);
    reset = 1'b1;

    send("^12@00003000: $5 <= 0000000a#");
    chk("l1_ft", 32'(format_type), 32'd1);
    chk("l1_time", 32'(time_val), 32'd12);
    chk("l1_pc", pc_val, 32'h3000);
    chk("l1_dest", dest_val, 32'd5);
    chk("l1_data", data_val, 32'ha);
    chk("l1_ok", 32'(ok_count), 32'd1);
    apply(" ");
    chk("l1_pulse_end", 32'(format_type), 32'd0);

    send("^9999@0000300c: *00001004<=deadbeef#");
    chk("l2_ft", 32'(format_type), 32'd2);
    chk("l2_dest", dest_val, 32'h1004);
    chk("l2_data", data_val, 32'hdeadbeef);

    send("^12345@00003000: $1 <= 00000001#");
    chk("l3_err", 32'(err_count), 32'd1);
    chk("l3_ok", 32'(ok_count), 32'd2);

    send("^1@0000300");
    send("^2@00003000: $1 <= 00000001#");
    chk("l4_err", 32'(err_count), 32'd2);
    chk("l4_ok", 32'(ok_count), 32'd3);
    chk("l4_time", 32'(time_val), 32'd2);

    send("^3@00003000: *0000abcd <= DEADBEEF#");
`ifdef CPU_TRACE_UPPER_HEX_EN
    chk("l5_ft", 32'(format_type), 32'd2);
    chk("l5_err", 32'(err_count), 32'd2);
`else
    chk("l5_ft", 32'(format_type), 32'd0);
    chk("l5_err", 32'(err_count), 32'd3);
`endif

    for (int i = 0; i < 300; i++) begin
      send(rnd_line());
      repeat ($urandom_range(0, 2)) apply(junk.getc($urandom_range(0, junk.len() - 1)));
    end

    send("^7@0000");
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ok", 32'(ok_count), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    chk("mid_rst_time", 32'(time_val), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send("^42@00000010: $3 <= 00000007#");
    chk("post_rst_ft", 32'(format_type), 32'd1);
    chk("post_rst_ok", 32'(ok_count), 32'd1);
    chk("post_rst_err", 32'(err_count), 32'd0);
    chk("post_rst_time", 32'(time_val), 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
